// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// The parity helper takes the widest legal word so one function serves every DATA_BITS.
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone = 2'd0,
    ParEven = 2'd1,
    ParOdd  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam logic IdleLevel = 1'b1;

  localparam int unsigned MaxDataBits = 9;

  // Zero-extension of narrower words leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MaxDataBits-1:0] data,
                                      input parity_mode_t           mode);
    logic x;
    x = ^data;
    return (mode == ParOdd) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO buffering words ahead of the UART shifter.
// Pushes are ignored when full and pops when empty; DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: only entries covered by count are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional parity, stop bits.
// Words are queued in a small FIFO so frames can run back-to-back without an idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          baud_clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          clear_error,
  output logic                          serial_out,
  output logic                          is_transmitting,
  output logic                          transmission_done,
  output logic                          error_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam parity_mode_t ParityCfg = parity_mode_t'(PARITY_MODE[1:0]);
  localparam int unsigned  ClkCntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned  BitCntW   = 4;

  localparam logic [ClkCntW-1:0] ClkLast  = ClkCntW'(CLKS_PER_BIT - 1);
  localparam logic [BitCntW-1:0] DataLast = BitCntW'(DATA_BITS - 1);
  localparam logic [BitCntW-1:0] StopLast = BitCntW'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [ClkCntW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 tick;
  logic                 load;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (baud_clock),
    .rst   (reset),
    .push  (fifo_push),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && !fifo_full;
  assign tick      = (clk_cnt_q == ClkLast);

  // A new overflow in the same cycle as clear_error keeps the flag set.
  assign error_d = (tx_valid && fifo_full) || (error_q && !clear_error);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = ((state_q == StIdle) || tick) ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    load      = 1'b0;
    fifo_pop  = 1'b0;

    unique case (state_q)
      StIdle: begin
        serial_d = IdleLevel;
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            if (ParityCfg != ParNone) begin
              state_d  = StParity;
              serial_d = parity_q;
            end else begin
              state_d  = StStop;
              serial_d = IdleLevel;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d   = StStop;
          bit_cnt_d = '0;
          serial_d  = IdleLevel;
        end
      end
      StStop: begin
        if (tick) begin
          if (bit_cnt_q == StopLast) begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d  = StIdle;
              serial_d = IdleLevel;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        serial_d = IdleLevel;
      end
    endcase

    // Pop and latch the next word; parity is taken from the latched copy, not live tx_data.
    if (load) begin
      fifo_pop  = 1'b1;
      state_d   = StStart;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = fifo_rdata;
      parity_d  = parity_bit(MaxDataBits'(fifo_rdata), ParityCfg);
      serial_d  = 1'b0;
    end
  end

  always_ff @(posedge baud_clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      serial_q  <= IdleLevel;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign serial_out        = serial_q;
  assign is_transmitting   = (state_q != StIdle);
  assign transmission_done = done_q;
  assign error_flag        = error_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets driven from one clock and reset.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance a: defaults (8 data, even parity, 1 stop, 1 clk/bit, depth 4)
  logic [7:0] data_a;
  logic       valid_a, ready_a, clr_a, ser_a, busy_a, done_a, err_a;
  logic [2:0] cnt_a;
  // Instance b: 7 data, odd parity, 2 stop, 4 clk/bit
  logic [6:0] data_b;
  logic       valid_b, ready_b, clr_b, ser_b, busy_b, done_b, err_b;
  logic [2:0] cnt_b;
  // Instance c: 8 clk/bit, depth 4
  logic [7:0] data_c;
  logic       valid_c, ready_c, clr_c, ser_c, busy_c, done_c, err_c;
  logic [2:0] cnt_c;
  // Instance d: 5 data, no parity
  logic [4:0] data_d;
  logic       valid_d, ready_d, clr_d, ser_d, busy_d, done_d, err_d;
  logic [2:0] cnt_d;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt_a = 0;
  int done_cnt_c = 0;

  uart_tx_param u_dut_a (
    .baud_clock(clk), .reset(reset), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .clear_error(clr_a), .serial_out(ser_a), .is_transmitting(busy_a),
    .transmission_done(done_a), .error_flag(err_a), .fifo_count(cnt_a)
  );

  uart_tx_param #(
    .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)
  ) u_dut_b (
    .baud_clock(clk), .reset(reset), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .clear_error(clr_b), .serial_out(ser_b), .is_transmitting(busy_b),
    .transmission_done(done_b), .error_flag(err_b), .fifo_count(cnt_b)
  );

  uart_tx_param #(
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(8), .FIFO_DEPTH(4)
  ) u_dut_c (
    .baud_clock(clk), .reset(reset), .tx_data(data_c), .tx_valid(valid_c), .tx_ready(ready_c),
    .clear_error(clr_c), .serial_out(ser_c), .is_transmitting(busy_c),
    .transmission_done(done_c), .error_flag(err_c), .fifo_count(cnt_c)
  );

  uart_tx_param #(
    .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)
  ) u_dut_d (
    .baud_clock(clk), .reset(reset), .tx_data(data_d), .tx_valid(valid_d), .tx_ready(ready_d),
    .clear_error(clr_d), .serial_out(ser_d), .is_transmitting(busy_d),
    .transmission_done(done_d), .error_flag(err_d), .fifo_count(cnt_d)
  );

  always @(negedge clk) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_c) done_cnt_c <= done_cnt_c + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] fr11;
    logic [10:0] fr_b;
    logic [21:0] fr22;
    logic [6:0]  fr7;
    logic [7:0]  rx;
    logic [3:0]  par_tbl;
    int          pushed;
    int          lows;
    int          base;
    int          waited;

    reset = 1'b1;
    {valid_a, valid_b, valid_c, valid_d} = '0;
    {clr_a, clr_b, clr_c, clr_d} = '0;
    data_a = '0; data_b = '0; data_c = '0; data_d = '0;
    step(3);

    // Reset values
    check_eq("rst_serial", 32'(ser_a), 32'd1);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_error", 32'(err_a), 32'd0);
    check_eq("rst_ready", 32'(ready_a), 32'd1);
    check_eq("rst_count", 32'(cnt_a), 32'd0);
    check_eq("rst_serial_b", 32'(ser_b), 32'd1);
    check_eq("rst_serial_c", 32'(ser_c), 32'd1);
    check_eq("rst_serial_d", 32'(ser_d), 32'd1);
    reset = 1'b0;
    step(1);

    // T1: 0xA5, even parity 0 -> bits start,b0..b7,par,stop (index 0 first on the line)
    fr11 = {1'b1, 1'b0, 8'hA5, 1'b0};
    data_a = 8'hA5; valid_a = 1'b1;
    step(1);
    valid_a = 1'b0; data_a = 8'hFF;
    check_eq("t1_pre_start", 32'(ser_a), 32'd1);
    check_eq("t1_count_after_push", 32'(cnt_a), 32'd1);
    step(1);
    for (int k = 0; k < 13; k++) begin
      if (k < 11) check_eq($sformatf("t1_bit%0d", k), 32'(ser_a), 32'(fr11[k]));
      check_eq($sformatf("t1_done_k%0d", k), 32'(done_a), 32'(k == 11));
      step(1);
    end
    check_eq("t1_done_count", 32'(done_cnt_a), 32'd1);

    // T2: 7 bits 0x00, odd parity -> 1, two stops, 4 clocks per bit
    fr_b = {1'b1, 1'b1, 1'b1, 7'h00, 1'b0};
    data_b = 7'h00; valid_b = 1'b1;
    step(1);
    valid_b = 1'b0;
    step(1);
    for (int k = 0; k < 45; k++) begin
      if (k < 44) begin
        check_eq($sformatf("t2_line_k%0d", k), 32'(ser_b), 32'(fr_b[k / 4]));
        check_eq($sformatf("t2_busy_k%0d", k), 32'(busy_b), 32'd1);
      end else begin
        check_eq("t2_busy_end", 32'(busy_b), 32'd0);
      end
      check_eq($sformatf("t2_done_k%0d", k), 32'(done_b), 32'(k == 44));
      step(1);
    end

    // T3: back-to-back 0x55 then 0x0F (both even parity 0), no idle gap
    fr22 = {1'b1, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0};
    data_a = 8'h55; valid_a = 1'b1;
    step(1);
    data_a = 8'h0F;
    step(1);
    valid_a = 1'b0;
    check_eq("t3_count_push_pop", 32'(cnt_a), 32'd1);
    for (int k = 0; k < 24; k++) begin
      if (k < 22) begin
        check_eq($sformatf("t3_line_k%0d", k), 32'(ser_a), 32'(fr22[k]));
        check_eq($sformatf("t3_busy_k%0d", k), 32'(busy_a), 32'd1);
      end
      check_eq($sformatf("t3_done_k%0d", k), 32'(done_a), 32'((k == 11) || (k == 22)));
      step(1);
    end
    check_eq("t3_count_end", 32'(cnt_a), 32'd0);
    check_eq("t3_done_count", 32'(done_cnt_a), 32'd3);

    // T4: fill depth-4 FIFO (first word popped immediately, so 5 pushes fit), then overflow
    pushed = 0;
    do begin
      data_c = 8'(8'h10 + pushed);
      valid_c = 1'b1;
      step(1);
      pushed++;
    end while (ready_c && pushed < 10);
    check_eq("t4_pushed", 32'(pushed), 32'd5);
    check_eq("t4_count_full", 32'(cnt_c), 32'd4);
    check_eq("t4_ready_full", 32'(ready_c), 32'd0);
    check_eq("t4_err_before", 32'(err_c), 32'd0);
    data_c = 8'hEE;
    step(1);
    valid_c = 1'b0;
    check_eq("t4_err_set", 32'(err_c), 32'd1);
    check_eq("t4_count_hold", 32'(cnt_c), 32'd4);
    clr_c = 1'b1;
    step(1);
    clr_c = 1'b0;
    check_eq("t4_err_clear", 32'(err_c), 32'd0);
    valid_c = 1'b1; clr_c = 1'b1;
    step(1);
    valid_c = 1'b0; clr_c = 1'b0;
    check_eq("t4_set_wins", 32'(err_c), 32'd1);
    clr_c = 1'b1;
    step(1);
    clr_c = 1'b0;
    check_eq("t4_err_clear2", 32'(err_c), 32'd0);

    waited = 0;
    while (!done_c && waited < 200) begin
      step(1);
      waited++;
    end
    check_eq("t4_frame1_done", 32'(done_c), 32'd1);
    // Parity of 0x11,0x12,0x13,0x14 (even): 0,0,1,0
    par_tbl = 4'b0100;
    for (int f = 1; f <= 4; f++) begin
      check_eq($sformatf("t4_start_f%0d", f), 32'(ser_c), 32'd0);
      step(4);
      rx = '0;
      for (int b = 0; b < 8; b++) begin
        step(8);
        rx[b] = ser_c;
      end
      step(8);
      check_eq($sformatf("t4_parity_f%0d", f), 32'(ser_c), 32'(par_tbl[f - 1]));
      step(8);
      check_eq($sformatf("t4_stop_f%0d", f), 32'(ser_c), 32'd1);
      check_eq($sformatf("t4_word_f%0d", f), 32'(rx), 32'(8'h10 + f));
      step(4);
    end
    check_eq("t4_last_done", 32'(done_c), 32'd1);
    check_eq("t4_idle_after", 32'(busy_c), 32'd0);
    lows = 0;
    repeat (100) begin
      step(1);
      if (!ser_c) lows++;
    end
    check_eq("t4_no_extra_frame", 32'(lows), 32'd0);
    check_eq("t4_done_count", 32'(done_cnt_c), 32'd5);
    check_eq("t4_count_end", 32'(cnt_c), 32'd0);

    // T5: reset during data bit 3 (0x34 has bit3 = 0) with two words queued
    data_a = 8'h34; valid_a = 1'b1;
    step(1);
    data_a = 8'h5A;
    step(1);
    data_a = 8'h66;
    step(1);
    valid_a = 1'b0;
    check_eq("t5_count_queued", 32'(cnt_a), 32'd2);
    step(3);
    check_eq("t5_bit3", 32'(ser_a), 32'd0);
    base = done_cnt_a;
    reset = 1'b1;
    #1;
    check_eq("t5_rst_serial", 32'(ser_a), 32'd1);
    check_eq("t5_rst_busy", 32'(busy_a), 32'd0);
    check_eq("t5_rst_ready", 32'(ready_a), 32'd1);
    check_eq("t5_rst_count", 32'(cnt_a), 32'd0);
    check_eq("t5_rst_done", 32'(done_a), 32'd0);
    step(2);
    reset = 1'b0;
    lows = 0;
    repeat (30) begin
      step(1);
      if (!ser_a || busy_a) lows++;
    end
    check_eq("t5_line_idle", 32'(lows), 32'd0);
    check_eq("t5_no_done", 32'(done_cnt_a - base), 32'd0);

    // T6: 5 bits 0x1F, no parity -> 0,1,1,1,1,1,1
    fr7 = {1'b1, 5'h1F, 1'b0};
    data_d = 5'h1F; valid_d = 1'b1;
    step(1);
    valid_d = 1'b0;
    step(1);
    for (int k = 0; k < 8; k++) begin
      if (k < 7) check_eq($sformatf("t6_bit%0d", k), 32'(ser_d), 32'(fr7[k]));
      check_eq($sformatf("t6_done_k%0d", k), 32'(done_d), 32'(k == 7));
      step(1);
    end
    check_eq("t6_idle", 32'(busy_d), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
